// File: rtl/prdec_fifo.sv
// rtl/prdec_fifo.sv - registered one-hot decoder feeding a small valid/ready FIFO
module prdec_fifo #(
  parameter int IDX_W = 2,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic                     in_none,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_onehot,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     word;
  logic             idx_hit;
  logic             push;
  logic             pop;
  logic             store;
  logic             drop;

  // Loop compare keeps the range check free of width games when N < 2**IDX_W.
  always_comb begin
    word    = '0;
    idx_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_idx == IDX_W'(i)) begin
        word[i] = 1'b1;
        idx_hit = 1'b1;
      end
    end
    if (in_none) begin
      word = '0;
    end
  end

  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign store      = push & (in_none | idx_hit);
  assign drop       = push & ~in_none & ~idx_hit;
  assign pop        = out_valid & out_ready;
  assign out_onehot = out_valid ? mem[rd_ptr] : '0;
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err     <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        err <= 1'b1;
      end
      case ({store, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: out_onehot is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= word;
    end
  end

endmodule

// File: tb/tb_prdec_fifo.sv
// tb/tb_prdec_fifo.sv - scoreboard bench for prdec_fifo with N=4 and N=3 instances
module tb_prdec_fifo;

  logic clk;
  int   compared   = 0;
  int   mismatched = 0;
  bit   done [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int NN = (gi == 0) ? 4 : 3;

    logic          rst_i;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_idx;
    logic          in_none;
    logic          out_valid;
    logic          out_ready;
    logic [NN-1:0] out_onehot;
    logic [2:0]    count;
    logic          err;

    prdec_fifo #(.IDX_W(2), .N(NN), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst_i),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_idx     (in_idx),
      .in_none    (in_none),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .count      (count),
      .err        (err)
    );

    logic [NN-1:0] exp_q [$];
    bit            m_err;
    bit            pend_store;
    bit            pend_drop;
    logic [NN-1:0] pend_word;

    // One clock of stimulus; returns whether the reference model accepts the word.
    task automatic cycle(input bit v, input int idx, input bit none, input bit ordy,
                         output bit accepted);
      @(negedge clk);
      if (pend_store) exp_q.push_back(pend_word);
      if (pend_drop) m_err = 1'b1;
      pend_store = 1'b0;
      pend_drop  = 1'b0;
      in_valid   = v;
      in_idx     = 2'(idx);
      in_none    = none;
      out_ready  = ordy;
      #1;
      accepted = v && (exp_q.size() != 4);
      if (accepted) begin
        if (none) begin
          pend_store = 1'b1;
          pend_word  = '0;
        end else if (idx < NN) begin
          pend_store = 1'b1;
          pend_word  = NN'(1) << idx;
        end else begin
          pend_drop = 1'b1;
        end
      end
    endtask

    task automatic push_hold(input int idx, input bit none, input bit ordy);
      bit acc;
      int tries;
      tries = 0;
      do begin
        cycle(1'b1, idx, none, ordy, acc);
        tries++;
      end while (!acc && tries < 20);
      chk($sformatf("n%0d_push_timeout", NN), int'(acc), 1);
    endtask

    task automatic idle(input int n, input bit ordy);
      bit acc;
      repeat (n) cycle(1'b0, $urandom_range(0, 3), 1'b0, ordy, acc);
    endtask

    task automatic do_reset();
      @(negedge clk);
      pend_store = 1'b0;
      pend_drop  = 1'b0;
      exp_q.delete();
      m_err    = 1'b0;
      rst_i    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
    endtask

    initial begin
      forever begin
        @(negedge clk);
        #2;
        if (!rst_i) begin
          chk($sformatf("n%0d_count", NN), int'(count), exp_q.size());
          chk($sformatf("n%0d_out_valid", NN), int'(out_valid), int'(exp_q.size() != 0));
          chk($sformatf("n%0d_in_ready", NN), int'(in_ready), int'(exp_q.size() != 4));
          chk($sformatf("n%0d_err", NN), int'(err), int'(m_err));
          chk($sformatf("n%0d_out_onehot", NN), int'(out_onehot),
              (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
          if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end

    initial begin
      bit acc;
      rst_i      = 1'b1;
      in_valid   = 1'b0;
      in_idx     = '0;
      in_none    = 1'b0;
      out_ready  = 1'b0;
      pend_store = 1'b0;
      pend_drop  = 1'b0;
      m_err      = 1'b0;
      do_reset();
      idle(2, 1'b0);

      for (int i = 0; i < 4; i++) push_hold(i, 1'b0, 1'b1);
      idle(3, 1'b1);

      push_hold(3, 1'b1, 1'b1);
      idle(3, 1'b1);

      push_hold(3, 1'b0, 1'b0);
      push_hold(2, 1'b0, 1'b0);
      push_hold(1, 1'b0, 1'b0);
      push_hold(0, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 3, 1'b0, 1'b0, acc);
      push_hold(3, 1'b0, 1'b1);
      idle(6, 1'b1);

      push_hold(0, 1'b0, 1'b0);
      push_hold(1, 1'b0, 1'b0);
      push_hold(2, 1'b0, 1'b1);
      idle(4, 1'b1);

      push_hold(3, 1'b0, 1'b1);
      push_hold(0, 1'b0, 1'b1);
      idle(3, 1'b1);
      push_hold(1, 1'b0, 1'b0);
      do_reset();
      idle(2, 1'b1);

      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 149) == 0) begin
          do_reset();
        end else begin
          cycle(($urandom_range(0, 2) != 0), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), acc);
        end
      end
      idle(8, 1'b1);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(done[0] && done[1]) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    chk("run_timeout", int'(done[0] && done[1]), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prdec_fifo.md
Name: prdec_fifo

Overview:
- Registered decoder: the reverse of the team's 4-to-2 priority encoder.
- Accepts encoded request indices (plus a "no request" flag) over a valid/ready handshake and decodes each one into a one-hot vector.
- Buffers decoded words in a small FIFO and presents them on a valid/ready output.
- Sits downstream of the priority encoder to regenerate per-line grant vectors for the consumers.

Parameters:
- IDX_W, 2, width of the encoded index input.
- N, 4, number of one-hot output lines; must satisfy 2 <= N <= 2**IDX_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  encoded word present.
- in_ready  output  1  block can accept a word this cycle.
- in_idx  input  IDX_W  encoded line index.
- in_none  input  1  no line requested; decodes to all-zero vector.
- out_valid  output  1  decoded word available at FIFO head.
- out_ready  input  1  consumer accepts head word.
- out_onehot  output  N  decoded vector at FIFO head.
- count  output  $clog2(DEPTH)+1  current occupancy.
- err  output  1  sticky: an out-of-range index was received.

Behaviour:
- Interface: already decided — one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - Write pointer, read pointer and count go to 0; err goes to 0.
  - After reset: out_valid=0, in_ready=1, out_onehot=0, count=0.
  - Storage contents are don't-care, but out_onehot must read 0 whenever out_valid=0.
  - Reset mid-operation discards all buffered words, overriding any same-cycle push or pop.
- Decode rules (evaluated at push):
  - in_none=1: word = all zeros, regardless of in_idx.
  - in_none=0 and in_idx < N: word has bit[in_idx]=1 and all other bits 0.
  - in_none=0 and in_idx >= N: word is not stored, err is set to 1 and stays set until rst. The handshake still completes (in_ready honoured), so the upstream never stalls. This case is only reachable when N < 2**IDX_W.
- Handshake:
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It is registered-state derived and has no combinational dependence on out_ready; a full FIFO does not accept a word even in a cycle that pops.
  - out_valid = (count != 0). out_onehot = head entry, driven from storage/registers and not directly from in_idx.
  - in_valid, in_idx and in_none may change freely when in_ready=0; no input is sampled unless a push occurs.
- Latency:
  - A word pushed into an empty FIFO appears with out_valid=1 in the cycle after the push edge.
  - There is no same-cycle bypass.
- Occupancy:
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged, both pointers advance.
  - A dropped out-of-range word counts as neither a stored push nor an occupancy change.
  - Pointers wrap modulo DEPTH.
- Boundaries:
  - Pop while empty is impossible (out_valid=0).
  - Push while full is impossible (in_ready=0).
  - Simultaneous push and pop at count=1 keeps out_valid high with the new word next.
- Ordering: strict FIFO order of accepted in-range words.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 → out_valid=0, in_ready=1, count=0, err=0, out_onehot=4'b0000.
- Decode sweep, out_ready=1: push idx 0,1,2,3 on consecutive cycles with in_none=0 → out_onehot is 0001, 0010, 0100, 1000 on cycles 1..4 after the first push; count never exceeds 1.
- No-request word: push in_none=1 with idx=2'b11 → one output word 4'b0000 with out_valid=1; err stays 0.
- Fill and stall: out_ready=0, push idx 3,2,1,0,3 → first four accepted; count=4, in_ready=0; fifth held with in_valid=1. Then raise out_ready → outputs 1000, 0100, 0010, 0001, then 1000 after the held word is accepted.
- Simultaneous push/pop at count=2 (FIFO holding 0001, 0010): push idx 2 while popping → count remains 2 and the output order continues 0010, 0100.
- Out-of-range (N=3, IDX_W=2): push idx 3 → in_ready accepts, count unchanged, err=1 from the next cycle. A following push of idx 0 yields 3'b001. A later rst clears err to 0 and flushes the FIFO.
